// File: rtl/pwm_decoder_pkg.sv
// Shared types and defaults for the PWM decoder slice.
package pwm_decoder_pkg;

  localparam int PWMDEC_CNT_BW_DEF = 8;

  typedef enum logic [0:0] {
    PWMDEC_IDLE = 1'b0,
    PWMDEC_MEAS = 1'b1
  } pwmdec_state_e;

endpackage

// File: rtl/pwm_decoder_if.sv
// PWM decoder bus: raw PWM input plus the measurement results it produces.
interface pwm_decoder_if
  import pwm_decoder_pkg::*;
#(
  parameter int CNT_BW = PWMDEC_CNT_BW_DEF
);

  logic              pwm_i;
  logic [CNT_BW-1:0] onCnt_o;
  logic [CNT_BW-1:0] periodCnt_o;
  logic              valid_o;
  logic              level_o;
  logic              timeout_o;

  modport master (
    input  pwm_i,
    output onCnt_o,
    output periodCnt_o,
    output valid_o,
    output level_o,
    output timeout_o
  );

  modport slave (
    output pwm_i,
    input  onCnt_o,
    input  periodCnt_o,
    input  valid_o,
    input  level_o,
    input  timeout_o
  );

endinterface

// File: rtl/sync_ff.sv
// Two-stage synchronizer for a single asynchronous pad input.
module sync_ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/pwm_decoder.sv
// Measures high time and period (in clk cycles) of an asynchronous PWM input.
// Overflow reporting with a sticky timeout flag is enabled by `define PWM_DEC_TIMEOUT_EN.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int CNT_BW = PWMDEC_CNT_BW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pwm_decoder_if.master bus
);

  localparam logic [CNT_BW-1:0] CNT_MAX = {CNT_BW{1'b1}};
  localparam logic [CNT_BW-1:0] CNT_ONE = {{(CNT_BW-1){1'b0}}, 1'b1};

  function automatic logic [CNT_BW-1:0] sat_add(input logic [CNT_BW-1:0] a, input logic inc);
    logic [CNT_BW-1:0] res;
    if (inc && (a != CNT_MAX)) begin
      res = a + CNT_ONE;
    end else begin
      res = a;
    end
    return res;
  endfunction

  pwmdec_state_e     r_state;
  pwmdec_state_e     w_state_nxt;

  logic              w_s;
  logic              r_s_d;
  logic              w_rise;

  logic [CNT_BW-1:0] r_period_ctr;
  logic [CNT_BW-1:0] r_on_ctr;
  logic [CNT_BW-1:0] r_period_cnt;
  logic [CNT_BW-1:0] r_on_cnt;
  logic              r_valid;
  logic              r_timeout;

  logic [CNT_BW-1:0] w_period_ctr_nxt;
  logic [CNT_BW-1:0] w_on_ctr_nxt;
  logic [CNT_BW-1:0] w_period_cnt_nxt;
  logic [CNT_BW-1:0] w_on_cnt_nxt;
  logic              w_valid_nxt;
  logic              w_timeout_nxt;

  sync_ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.pwm_i),
    .q_o   (w_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_s;
    end
  end

  assign w_rise = w_s & ~r_s_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= PWMDEC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The rising-edge cycle is always counted as the first high cycle of the new period.
  always_comb begin
    w_state_nxt      = r_state;
    w_period_ctr_nxt = r_period_ctr;
    w_on_ctr_nxt     = r_on_ctr;
    w_period_cnt_nxt = r_period_cnt;
    w_on_cnt_nxt     = r_on_cnt;
    w_valid_nxt      = 1'b0;
    w_timeout_nxt    = r_timeout;

    case (r_state)
      PWMDEC_IDLE: begin
        if (w_rise) begin
          w_period_ctr_nxt = CNT_ONE;
          w_on_ctr_nxt     = CNT_ONE;
          w_timeout_nxt    = 1'b0;
          w_state_nxt      = PWMDEC_MEAS;
        end else begin
          w_state_nxt      = PWMDEC_IDLE;
        end
      end

      PWMDEC_MEAS: begin
        if (w_rise) begin
          w_period_cnt_nxt = r_period_ctr;
          w_on_cnt_nxt     = r_on_ctr;
          w_valid_nxt      = 1'b1;
          w_timeout_nxt    = 1'b0;
          w_period_ctr_nxt = CNT_ONE;
          w_on_ctr_nxt     = CNT_ONE;
          w_state_nxt      = PWMDEC_MEAS;
        end
`ifdef PWM_DEC_TIMEOUT_EN
        else if (r_period_ctr == CNT_MAX) begin
          w_period_cnt_nxt = CNT_MAX;
          w_on_cnt_nxt     = sat_add(r_on_ctr, w_s);
          w_valid_nxt      = 1'b1;
          w_timeout_nxt    = 1'b1;
          w_state_nxt      = PWMDEC_IDLE;
        end
`endif
        else begin
          w_period_ctr_nxt = sat_add(r_period_ctr, 1'b1);
          w_on_ctr_nxt     = sat_add(r_on_ctr, w_s);
          w_state_nxt      = PWMDEC_MEAS;
        end
      end

      default: begin
        w_state_nxt = PWMDEC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_period_ctr <= '0;
      r_on_ctr     <= '0;
      r_period_cnt <= '0;
      r_on_cnt     <= '0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_period_ctr <= w_period_ctr_nxt;
      r_on_ctr     <= w_on_ctr_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_on_cnt     <= w_on_cnt_nxt;
      r_valid      <= w_valid_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign bus.onCnt_o     = r_on_cnt;
  assign bus.periodCnt_o = r_period_cnt;
  assign bus.valid_o     = r_valid;
  assign bus.level_o     = w_s;
  assign bus.timeout_o   = r_timeout;

endmodule
